// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one variable-latency memory between fetch and data ports
// Data-first arbitration with a bounded data streak, per-access timeout and sticky error.
module unified_mem_arbiter #(
  parameter int width        = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [width-1:0] if_addr,
  output logic [width-1:0] if_rdata,
  output logic             if_valid,
  output logic             if_stall,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [width-1:0] dm_addr,
  input  logic [width-1:0] dm_wdata,
  output logic [width-1:0] dm_rdata,
  output logic             dm_valid,
  output logic             dm_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_DONE_I = 3'd3;
  localparam logic [2:0] S_DONE_D = 3'd4;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [width-1:0] mem_addr_q, mem_addr_d;
  logic [width-1:0] mem_wdata_q, mem_wdata_d;
  logic [width-1:0] if_rdata_q, if_rdata_d;
  logic [width-1:0] dm_rdata_q, dm_rdata_d;
  logic             if_valid_q, if_valid_d;
  logic             dm_valid_q, dm_valid_d;
  logic             err_q, err_d;
  logic [3:0]       streak_q, streak_d;
  logic [7:0]       wait_q, wait_d;

  logic can_grant, if_elig, dm_elig, grant_i, grant_d, finish;

  // The port that just completed sits out its own DONE cycle so the other port gets a turn.
  assign can_grant = (state_q != S_BUSY_I) && (state_q != S_BUSY_D);
  assign if_elig   = if_req && (state_q != S_DONE_I);
  assign dm_elig   = dm_req && (state_q != S_DONE_D);
  assign grant_i   = can_grant && if_elig && (!dm_elig || streak_q == STREAK_MAX);
  assign grant_d   = can_grant && dm_elig && !grant_i;
  assign finish    = mem_ready || (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    if (state_q == S_BUSY_I || state_q == S_BUSY_D) begin
      if (finish) begin
        mem_req_d = 1'b0;
        if (!mem_ready) err_d = 1'b1;
        if (state_q == S_BUSY_I) begin
          state_d    = S_DONE_I;
          if_valid_d = 1'b1;
          if_rdata_d = mem_ready ? mem_rdata : '0;
        end else begin
          state_d    = S_DONE_D;
          dm_valid_d = 1'b1;
          dm_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
        end
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else if (grant_i) begin
      state_d    = S_BUSY_I;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
      streak_d   = 4'd0;
      wait_d     = 8'd0;
    end else if (grant_d) begin
      state_d     = S_BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      wait_d      = 8'd0;
      if (!if_req)                     streak_d = 4'd0;
      else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
    end else begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      streak_q    <= 4'd0;
      wait_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  bit          grants[$];
  int          lat = 1;
  bit          force_ready = 1'b0;
  int          mcnt = 0;
  logic        prev_req = 1'b0;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008000A;
    return a * 3 + 32'h1000_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: lat = cycle of mem_req in which mem_ready pulses, 0 = never.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mcnt      = mem_req ? mcnt + 1 : 0;
      mem_ready = force_ready || (mem_req && lat != 0 && mcnt == lat);
      mem_rdata = mem_ready ? mem_f(mem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: pops the scoreboard on each valid pulse and logs grants (address >= 0x100 = data).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && !prev_req) grants.push_back(mem_addr >= 32'h100);
      prev_req = mem_req;
      if (if_valid) begin
        if (if_exp.size() == 0) chk("if_valid_unexpected", {31'b0, if_valid}, 32'h0);
        else chk("if_rdata", if_rdata, if_exp.pop_front());
      end
      if (dm_valid) begin
        if (dm_exp.size() == 0) chk("dm_valid_unexpected", {31'b0, dm_valid}, 32'h0);
        else chk("dm_rdata", dm_rdata, dm_exp.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, fcnt, g0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_dm_valid", {31'b0, dm_valid}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    tick();

    // single fetch, zero-wait memory
    if_addr = 32'h40; if_req = 1'b1; if_exp.push_back(32'h2008000A);
    #1 chk("t1_stall_t", {31'b0, if_stall}, 32'h1);
    tick();
    chk("t1_mem_req", {31'b0, mem_req}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_mem_we", {31'b0, mem_we}, 32'h0);
    chk("t1_stall_t1", {31'b0, if_stall}, 32'h1);
    chk("t1_valid_early", {31'b0, if_valid}, 32'h0);
    tick();
    chk("t1_valid", {31'b0, if_valid}, 32'h1);
    chk("t1_rdata", if_rdata, 32'h2008000A);
    chk("t1_stall_t2", {31'b0, if_stall}, 32'h0);
    chk("t1_mem_req_drop", {31'b0, mem_req}, 32'h0);
    if_req = 1'b0;
    tick();
    chk("t1_valid_pulse", {31'b0, if_valid}, 32'h0);

    // simultaneous fetch + data read, latency 3
    @(negedge clk); lat = 3;
    if_addr = 32'h80; if_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
    dm_exp.push_back(mem_f(32'h200)); if_exp.push_back(mem_f(32'h80));
    g0 = grants.size();
    tick();
    n = 0;
    while (!dm_valid && n < 20) begin tick(); n++; end
    chk("t2_dm_valid", {31'b0, dm_valid}, 32'h1);
    chk("t2_dm_latency", n, 3);
    dm_req = 1'b0;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("t2_if_after_dm", n, 4);
    chk("t2_grant_count", grants.size() - g0, 2);
    if (grants.size() - g0 == 2) begin
      chk("t2_first_is_data", {31'b0, grants[g0]}, 32'h1);
      chk("t2_second_is_fetch", {31'b0, grants[g0+1]}, 32'h0);
    end
    if_req = 1'b0;
    tick();

    // streak limit: fetch yields in DONE_D cycles so only the streak rule lets it in
    @(negedge clk); lat = 1; rst = 1'b1;
    tick();
    rst = 1'b0;
    g0 = grants.size(); fcnt = 0;
    if_addr = 32'h10; if_req = 1'b1; dm_addr = 32'h300; dm_we = 1'b0; dm_req = 1'b1;
    if_exp.push_back(mem_f(32'h10)); dm_exp.push_back(mem_f(32'h300));
    n = 0;
    while (fcnt < 3 && n < 300) begin
      tick(); n++;
      if (if_valid) begin
        fcnt++;
        if (fcnt < 3) if_exp.push_back(mem_f(32'h10));
      end
      if (dm_valid) begin
        if_req = 1'b0;
        dm_exp.push_back(mem_f(32'h300));
      end else if (fcnt < 3) begin
        if_req = 1'b1;
      end
    end
    chk("t3_fetch_done", fcnt, 3);
    if_req = 1'b0; dm_req = 1'b0;
    if (dm_exp.size() > 0) void'(dm_exp.pop_back());
    tick(); tick();
    chk("t3_grant_count", grants.size() - g0, 15);
    if (grants.size() - g0 == 15) begin
      for (int i = 0; i < 15; i++)
        chk($sformatf("t3_grant_%0d", i), {31'b0, grants[g0+i]}, (i % 5 == 4) ? 32'h0 : 32'h1);
    end

    // data write
    @(negedge clk); lat = 2;
    dm_addr = 32'h100; dm_wdata = 32'hCAFEF00D; dm_we = 1'b1; dm_req = 1'b1; dm_exp.push_back(32'h0);
    tick();
    chk("t4_mem_req", {31'b0, mem_req}, 32'h1);
    chk("t4_mem_we", {31'b0, mem_we}, 32'h1);
    chk("t4_mem_addr", mem_addr, 32'h100);
    chk("t4_mem_wdata", mem_wdata, 32'hCAFEF00D);
    n = 0;
    while (!dm_valid && n < 20) begin tick(); n++; end
    chk("t4_dm_valid", {31'b0, dm_valid}, 32'h1);
    chk("t4_dm_rdata_zero", dm_rdata, 32'h0);
    chk("t4_latency", n, 2);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();

    // timeout
    @(negedge clk); lat = 0;
    dm_addr = 32'h180; dm_req = 1'b1; dm_exp.push_back(32'h0);
    tick();
    n = 0; k = 0;
    while (!dm_valid && k < 200) begin
      if (mem_req) n++;
      tick(); k++;
    end
    chk("t5_busy_cycles", n, 64);
    chk("t5_dm_valid", {31'b0, dm_valid}, 32'h1);
    chk("t5_err", {31'b0, err}, 32'h1);
    chk("t5_mem_req_drop", {31'b0, mem_req}, 32'h0);
    dm_req = 1'b0;
    @(negedge clk); lat = 1;
    if_addr = 32'h44; if_req = 1'b1; if_exp.push_back(mem_f(32'h44));
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("t5_later_valid", {31'b0, if_valid}, 32'h1);
    chk("t5_err_sticky", {31'b0, err}, 32'h1);
    if_req = 1'b0;
    tick();

    // reset during BUSY_D, then a stray mem_ready
    @(negedge clk); lat = 0;
    dm_addr = 32'h1C0; dm_we = 1'b0; dm_req = 1'b1;
    tick(); tick();
    chk("t6_busy", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_req = 1'b0;
    chk("t6_mem_req", {31'b0, mem_req}, 32'h0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_err", {31'b0, err}, 32'h0);
    chk("t6_dm_rdata", dm_rdata, 32'h0);
    @(negedge clk); force_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_dm_valid", {31'b0, dm_valid}, 32'h0);
      chk("t6_idle_mem_req", {31'b0, mem_req}, 32'h0);
      chk("t6_err_clear", {31'b0, err}, 32'h0);
    end
    @(negedge clk); force_ready = 1'b0;
    tick(); tick();
    chk("if_scoreboard_empty", if_exp.size(), 0);
    chk("dm_scoreboard_empty", dm_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequential arbiter that shares one single-ported, variable-latency unified memory between the pipelined MIPS core's instruction-fetch port and its data-memory (MEM-stage) port. It serialises requests and applies data-first priority with a bounded anti-starvation rule for fetch. It returns read data with one-cycle valid pulses and drives per-port stall lines toward the hazard unit. It sits between the datapath's IF/MEM stages and the external memory model.

## Interface
- `width`, 32: address and data width.
- `MAX_D_STREAK`, 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- `TIMEOUT`, 64: BUSY cycles without `mem_ready` before forced completion; range 2..255.

Ports:
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `if_req` in 1: fetch request (level). Held with a stable `if_addr` until `if_valid`.
- `if_addr` in width: fetch address.
- `if_rdata` out width: fetched instruction. Registered; meaningful only while `if_valid` is high.
- `if_valid` out 1: one-cycle pulse marking fetch completion.
- `if_stall` out 1: `if_req & ~if_valid` (combinational).
- `dm_req` in 1: data request (level). Held with stable address, write enable and write data until `dm_valid`.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in width: data address.
- `dm_wdata` in width: data to write.
- `dm_rdata` out width: read data. Value is 0 on a write completion.
- `dm_valid` out 1: one-cycle pulse marking data completion.
- `dm_stall` out 1: `dm_req & ~dm_valid` (combinational).
- `mem_req` out 1: memory request. Registered; held until `mem_ready` or timeout.
- `mem_we` out 1: write enable. Registered.
- `mem_addr` out width: memory address. Registered.
- `mem_wdata` out width: memory write data. Registered.
- `mem_rdata` in width: memory read data. Valid in the cycle `mem_ready` is high.
- `mem_ready` in 1: completion pulse. May be high in the first cycle `mem_req` is high.
- `err` out 1: sticky timeout flag, cleared only by `rst`.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Grant decision is made in IDLE, DONE_I and DONE_D.
  - In DONE_I, `if_req` is excluded from the decision.
  - In DONE_D, `dm_req` is excluded from the decision.
- Priority: data wins over fetch, except when `d_streak == MAX_D_STREAK` and `if_req` is eligible; then fetch wins.
- A grant moves the FSM to BUSY_I or BUSY_D. In the same edge it registers `mem_req=1` and latches address, write enable and write data from the winning port; fetch grants set `mem_we=0`.
- With no eligible request, the FSM goes to IDLE and `mem_req=0`.
- `d_streak` (4 bits) updates at each grant:
  - +1 on a data grant while `if_req` is high.
  - Cleared on a fetch grant.
  - Cleared on a data grant while `if_req` is low.
  - Saturates at `MAX_D_STREAK`.
- BUSY_x with `mem_ready=1`:
  - Go to DONE_x and drop `mem_req`.
  - Register `x_rdata` from `mem_rdata`; data writes register 0 instead.
  - Raise `x_valid` for the DONE cycle.
- BUSY_x timeout: the wait counter reaches `TIMEOUT-1` with no `mem_ready`.
  - Go to DONE_x and drop `mem_req`.
  - Set `x_rdata=0` and `x_valid=1`.
  - Set `err=1`.
- `mem_ready` in IDLE/DONE is ignored.
- The wait counter clears on every grant.
- Reset values: state IDLE, `mem_req`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, `if_rdata`/`dm_rdata` 0, both valids 0, `err` 0, `d_streak` 0, wait counter 0.

## Timing
- Request first seen high in IDLE at edge t: `mem_req` is high from t+1.
- Zero-wait memory (`mem_ready` in the first cycle of `mem_req`): `x_valid` is high in cycle t+2, giving 2-cycle minimum latency.
- Each memory wait cycle adds 1 cycle of latency.
- Back-to-back operation:
  - The DONE cycle for one port can grant the other port, so `mem_req` re-asserts in the cycle after DONE.
  - Sustained alternating throughput is one access per (memory latency + 1) cycles.
  - The same port cannot be re-granted in its own DONE cycle. Its earliest re-grant is the cycle after DONE, from IDLE.
- Requesters must drop or refresh their request in the cycle their valid is seen.
- Reset mid-transaction: the next edge forces the reset state, including `mem_req=0`. Any later `mem_ready` is ignored, and no valid pulse is produced for the aborted access.
- Simultaneous `if_req`/`dm_req` rising in IDLE: the data port is granted unless the streak limit applies.

## Test plan
- Single fetch, zero-wait memory, `if_addr=0x40`, `mem_rdata=0x2008000A` → `mem_req` at t+1, `if_valid` pulse at t+2 with `if_rdata=0x2008000A`; `if_stall` high t..t+1.
- Simultaneous `if_req` + `dm_req` read, memory latency 3 → data is served first and `dm_valid` fires; fetch is granted in the DONE_D cycle; `if_valid` follows 4 cycles after `dm_valid`.
- `dm_req` held continuously with rapid re-requests, `if_req` held, `MAX_D_STREAK=4` → exactly 4 data grants, then 1 fetch grant, pattern repeats.
- Data write `dm_addr=0x100`, `dm_wdata=0xCAFEF00D` → `mem_we=1` with matching address and data while `mem_req` is high; `dm_valid` fires with `dm_rdata=0`.
- Memory never asserts `mem_ready`, `TIMEOUT=64` → completion pulse after 64 BUSY cycles with rdata 0; `err=1` and it stays high through later normal transactions until `rst`.
- Assert `rst` for one cycle during BUSY_D, then a stray `mem_ready` → all outputs at reset values; no `dm_valid`; `err` stays 0.
